// File: rtl/ps2_key_display.sv
// ps2_key_display
// ---------------------------------------------------------------------------
// Turns the PS/2 scan-code byte stream into a held-key display. It decodes the
// make / break (F0) / extended (E0) prefix protocol, tracks the one key that
// is currently held, and drives eight seven-segment digits:
//   seg1:seg0  held scan code (hex)
//   seg3:seg2  ASCII of the held key (letters and digits only, non-extended)
//   seg5:seg4  count of distinct presses (blank until the first press)
//   seg6       "E" while the held key is an extended key
//   seg7       always blank
// Handshake: code_valid is a one-cycle strobe that qualifies code_data. There
// is no ready; every strobe is consumed in the cycle it is presented. All
// outputs are registered and reflect a strobe on the following clock edge.
//
// Ports:
//   clk          system clock
//   rst          asynchronous, active-high reset
//   code_valid   strobe, code_data valid this cycle
//   code_data    received scan-code byte
//   key_held     a key is currently held
//   o_seg0..7    digit patterns, bit0=a .. bit6=g, bit7=dp (dp never lit)
// ---------------------------------------------------------------------------
module ps2_key_display #(
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit CNT_SAT        = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       code_valid,
    input  logic [7:0] code_data,
    output logic       key_held,
    output logic [7:0] o_seg0,
    output logic [7:0] o_seg1,
    output logic [7:0] o_seg2,
    output logic [7:0] o_seg3,
    output logic [7:0] o_seg4,
    output logic [7:0] o_seg5,
    output logic [7:0] o_seg6,
    output logic [7:0] o_seg7
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    localparam logic [7:0] SEG_BLANK = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;

    // Active-high glyph, bit0=a .. bit6=g.
    function automatic logic [6:0] hex_glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
            4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
            4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
            4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
        endcase
        return g;
    endfunction

    // Applies blanking and output polarity; dp is always off.
    function automatic logic [7:0] seg_drive(input logic lit, input logic [6:0] pat);
        logic [7:0] on;
        on = lit ? {1'b0, pat} : 8'h00;
        return SEG_ACTIVE_LOW ? ~on : on;
    endfunction

    // {mapped, ascii} for non-extended set-2 scan codes.
    function automatic logic [8:0] ascii_of(input logic [7:0] c);
        logic [8:0] a;
        case (c)
            8'h1C: a = {1'b1, 8'h41};  8'h32: a = {1'b1, 8'h42};  8'h21: a = {1'b1, 8'h43};
            8'h23: a = {1'b1, 8'h44};  8'h24: a = {1'b1, 8'h45};  8'h2B: a = {1'b1, 8'h46};
            8'h34: a = {1'b1, 8'h47};  8'h33: a = {1'b1, 8'h48};  8'h43: a = {1'b1, 8'h49};
            8'h3B: a = {1'b1, 8'h4A};  8'h42: a = {1'b1, 8'h4B};  8'h4B: a = {1'b1, 8'h4C};
            8'h3A: a = {1'b1, 8'h4D};  8'h31: a = {1'b1, 8'h4E};  8'h44: a = {1'b1, 8'h4F};
            8'h4D: a = {1'b1, 8'h50};  8'h15: a = {1'b1, 8'h51};  8'h2D: a = {1'b1, 8'h52};
            8'h1B: a = {1'b1, 8'h53};  8'h2C: a = {1'b1, 8'h54};  8'h3C: a = {1'b1, 8'h55};
            8'h2A: a = {1'b1, 8'h56};  8'h1D: a = {1'b1, 8'h57};  8'h22: a = {1'b1, 8'h58};
            8'h35: a = {1'b1, 8'h59};  8'h1A: a = {1'b1, 8'h5A};
            8'h45: a = {1'b1, 8'h30};  8'h16: a = {1'b1, 8'h31};  8'h1E: a = {1'b1, 8'h32};
            8'h26: a = {1'b1, 8'h33};  8'h25: a = {1'b1, 8'h34};  8'h2E: a = {1'b1, 8'h35};
            8'h36: a = {1'b1, 8'h36};  8'h3D: a = {1'b1, 8'h37};  8'h3E: a = {1'b1, 8'h38};
            8'h46: a = {1'b1, 8'h39};
            default: a = 9'h000;
        endcase
        return a;
    endfunction

    logic [1:0] state_q,   state_d;
    logic       held_q,    held_d;
    logic [7:0] code_q,    code_d;
    logic       ext_q,     ext_d;
    logic [7:0] cnt_q,     cnt_d;
    logic       pressed_q, pressed_d;   // at least one press since reset
    logic [7:0] seg_q [8];
    logic [7:0] seg_d [8];

    logic       do_make;
    logic       do_break;
    logic       ev_ext;
    logic       is_noise;
    logic [8:0] ascii;

    // Protocol decode: which event (if any) this strobe produces.
    always_comb begin
        state_d  = state_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        ev_ext   = 1'b0;
        is_noise = (code_data == 8'h00) || (code_data == 8'hAA) || (code_data == 8'hE1) ||
                   (code_data == 8'hEE) || (code_data == 8'hFA) || (code_data == 8'hFC) ||
                   (code_data == 8'hFE) || (code_data == 8'hFF);
        if (code_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (code_data == 8'hE0)      state_d = ST_EXT;
                    else if (code_data == 8'hF0) state_d = ST_BRK;
                    else if (!is_noise)          do_make = 1'b1;
                end
                ST_EXT: begin
                    if (code_data == 8'hF0)      state_d = ST_EXT_BRK;
                    else if (code_data == 8'hE0) state_d = ST_EXT;
                    else begin
                        do_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    if (code_data == 8'hE0) state_d = ST_EXT;
                    else begin
                        do_break = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                default: begin
                    do_break = 1'b1;
                    ev_ext   = 1'b1;
                    state_d  = ST_IDLE;
                end
            endcase
        end
    end

    // Held-key tracking. A make matching the held key is a typematic repeat.
    always_comb begin
        held_d    = held_q;
        code_d    = code_q;
        ext_d     = ext_q;
        cnt_d     = cnt_q;
        pressed_d = pressed_q;
        if (do_make && !(held_q && {ext_q, code_q} == {ev_ext, code_data})) begin
            held_d    = 1'b1;
            code_d    = code_data;
            ext_d     = ev_ext;
            pressed_d = 1'b1;
            if (!(CNT_SAT && cnt_q == 8'hFF)) cnt_d = cnt_q + 8'd1;
        end
        if (do_break && held_q && {ext_q, code_q} == {ev_ext, code_data}) begin
            held_d = 1'b0;
        end
    end

    // Display is computed from next-state values so it lands with the state.
    always_comb begin
        ascii    = ascii_of(code_d);
        seg_d[0] = seg_drive(held_d, hex_glyph(code_d[3:0]));
        seg_d[1] = seg_drive(held_d, hex_glyph(code_d[7:4]));
        seg_d[2] = seg_drive(held_d && !ext_d && ascii[8], hex_glyph(ascii[3:0]));
        seg_d[3] = seg_drive(held_d && !ext_d && ascii[8], hex_glyph(ascii[7:4]));
        seg_d[4] = seg_drive(pressed_d, hex_glyph(cnt_d[3:0]));
        seg_d[5] = seg_drive(pressed_d, hex_glyph(cnt_d[7:4]));
        seg_d[6] = seg_drive(held_d && ext_d, hex_glyph(4'hE));
        seg_d[7] = SEG_BLANK;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            held_q    <= 1'b0;
            code_q    <= 8'h00;
            ext_q     <= 1'b0;
            cnt_q     <= 8'h00;
            pressed_q <= 1'b0;
            for (int i = 0; i < 8; i++) seg_q[i] <= SEG_BLANK;
        end else begin
            state_q   <= state_d;
            held_q    <= held_d;
            code_q    <= code_d;
            ext_q     <= ext_d;
            cnt_q     <= cnt_d;
            pressed_q <= pressed_d;
            for (int i = 0; i < 8; i++) seg_q[i] <= seg_d[i];
        end
    end

    assign key_held = held_q;
    assign o_seg0   = seg_q[0];
    assign o_seg1   = seg_q[1];
    assign o_seg2   = seg_q[2];
    assign o_seg3   = seg_q[3];
    assign o_seg4   = seg_q[4];
    assign o_seg5   = seg_q[5];
    assign o_seg6   = seg_q[6];
    assign o_seg7   = seg_q[7];

endmodule

// File: tb/tb_ps2_key_display.sv
// Directed bench for ps2_key_display. Two instances share the stimulus: one
// with a wrapping press counter and one with a saturating counter.
module tb_ps2_key_display;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] code_data = 8'h00;

    logic       key_held,   s_key_held;
    logic [7:0] seg [8];
    logic [7:0] s_seg [8];

    int checks = 0;
    int errors = 0;

    // Active-low glyphs (segment lit when bit is 0), hand-derived.
    localparam logic [7:0] BL = 8'hFF;
    function automatic logic [7:0] g(input logic [3:0] n);
        logic [7:0] r;
        case (n)
            4'h0: r = 8'hC0;  4'h1: r = 8'hF9;  4'h2: r = 8'hA4;  4'h3: r = 8'hB0;
            4'h4: r = 8'h99;  4'h5: r = 8'h92;  4'h6: r = 8'h82;  4'h7: r = 8'hF8;
            4'h8: r = 8'h80;  4'h9: r = 8'h90;  4'hA: r = 8'h88;  4'hB: r = 8'h83;
            4'hC: r = 8'hC6;  4'hD: r = 8'hA1;  4'hE: r = 8'h86;  default: r = 8'h8E;
        endcase
        return r;
    endfunction

    always #5 clk = ~clk;

    ps2_key_display #(.SEG_ACTIVE_LOW(1'b1), .CNT_SAT(1'b0)) dut (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code_data(code_data),
        .key_held(key_held),
        .o_seg0(seg[0]), .o_seg1(seg[1]), .o_seg2(seg[2]), .o_seg3(seg[3]),
        .o_seg4(seg[4]), .o_seg5(seg[5]), .o_seg6(seg[6]), .o_seg7(seg[7])
    );

    ps2_key_display #(.SEG_ACTIVE_LOW(1'b1), .CNT_SAT(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .code_valid(code_valid), .code_data(code_data),
        .key_held(s_key_held),
        .o_seg0(s_seg[0]), .o_seg1(s_seg[1]), .o_seg2(s_seg[2]), .o_seg3(s_seg[3]),
        .o_seg4(s_seg[4]), .o_seg5(s_seg[5]), .o_seg6(s_seg[6]), .o_seg7(s_seg[7])
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks key_held and all eight digits of the wrapping instance.
    task automatic check_all(input string tag, input logic kh,
                             input logic [7:0] e0, input logic [7:0] e1,
                             input logic [7:0] e2, input logic [7:0] e3,
                             input logic [7:0] e4, input logic [7:0] e5,
                             input logic [7:0] e6);
        check({tag, "_held"}, {7'd0, key_held}, {7'd0, kh});
        check({tag, "_s0"}, seg[0], e0);
        check({tag, "_s1"}, seg[1], e1);
        check({tag, "_s2"}, seg[2], e2);
        check({tag, "_s3"}, seg[3], e3);
        check({tag, "_s4"}, seg[4], e4);
        check({tag, "_s5"}, seg[5], e5);
        check({tag, "_s6"}, seg[6], e6);
        check({tag, "_s7"}, seg[7], BL);
    endtask

    // One-cycle strobe; returns on the falling edge after the capturing edge.
    task automatic send(input logic [7:0] b);
        @(negedge clk);
        code_valid = 1'b1;
        code_data  = b;
        @(negedge clk);
        code_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        // Reset: everything blank.
        do_reset();
        @(negedge clk);
        check_all("reset", 1'b0, BL, BL, BL, BL, BL, BL, BL);

        // Press A (1C): code 1C, ASCII 41, count 01.
        send(8'h1C);
        check_all("make_a", 1'b1, g(4'hC), g(4'h1), g(4'h1), g(4'h4), g(4'h1), g(4'h0), BL);

        // Release A: held-key digits blank, count stays 01.
        send(8'hF0);
        check("brk_pending_held", {7'd0, key_held}, 8'd1);
        send(8'h1C);
        check_all("break_a", 1'b0, BL, BL, BL, BL, g(4'h1), g(4'h0), BL);

        // New press of A counts once (02), then repeats are ignored.
        for (int i = 0; i < 5; i++) send(8'h1C);
        check_all("typematic", 1'b1, g(4'hC), g(4'h1), g(4'h1), g(4'h4), g(4'h2), g(4'h0), BL);

        // Rollover to B (32): ASCII 42, count 03.
        send(8'h32);
        check_all("rollover_b", 1'b1, g(4'h2), g(4'h3), g(4'h2), g(4'h4), g(4'h3), g(4'h0), BL);

        // Extended 75: ASCII blank, seg6 "E", count 04.
        send(8'hE0);
        check("ext_prefix_s0", seg[0], g(4'h2));
        send(8'h75);
        check_all("ext_make", 1'b1, g(4'h5), g(4'h7), BL, BL, g(4'h4), g(4'h0), g(4'hE));

        // Non-extended break of 75 does not match the extended held key.
        send(8'hF0);
        send(8'h75);
        check_all("nonext_brk", 1'b1, g(4'h5), g(4'h7), BL, BL, g(4'h4), g(4'h0), g(4'hE));

        // Extended break releases it.
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check_all("ext_brk", 1'b0, BL, BL, BL, BL, g(4'h4), g(4'h0), BL);

        // Ignored bytes in IDLE.
        send(8'hAA);
        send(8'hFA);
        check_all("ignored", 1'b0, BL, BL, BL, BL, g(4'h4), g(4'h0), BL);

        // Digit key 0 (45) -> ASCII 30, count 05.
        send(8'h45);
        check_all("digit0", 1'b1, g(4'h5), g(4'h4), g(4'h0), g(4'h3), g(4'h5), g(4'h0), BL);

        // Reset in the middle of a break prefix discards it.
        send(8'hF0);
        do_reset();
        @(negedge clk);
        check_all("mid_reset", 1'b0, BL, BL, BL, BL, BL, BL, BL);
        send(8'h1C);
        check_all("post_reset_make", 1'b1, g(4'hC), g(4'h1), g(4'h1), g(4'h4), g(4'h1), g(4'h0), BL);

        // Counter boundary: 256 alternating presses from a fresh reset.
        do_reset();
        for (int i = 0; i < 255; i++) send(i[0] ? 8'h32 : 8'h1C);
        check("cnt255_s4", seg[4], g(4'hF));
        check("cnt255_s5", seg[5], g(4'hF));
        send(8'h32);
        check("wrap_s4", seg[4], g(4'h0));
        check("wrap_s5", seg[5], g(4'h0));
        check("sat_s4", s_seg[4], g(4'hF));
        check("sat_s5", s_seg[5], g(4'hF));
        check("sat_held", {7'd0, s_key_held}, 8'd1);
        send(8'h1C);
        check("wrap_next_s4", seg[4], g(4'h1));
        check("sat_next_s4", s_seg[4], g(4'hF));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
